// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: handshake and data bundle for the pipelined add/sub unit.
//   master: drives operands, opcode, in_valid and out_ready (producer/consumer side)
//   slave : the addsub_pipe block; drives in_ready, out_valid, result and flags
interface addsub_pipe_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ALU_dat1;
  logic [WIDTH-1:0] ALU_dat2;
  logic [4:0]       Instruction_to_ALU;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] AddSub_out;
  logic             AddSub_overflow;
  logic             AddSub_zero;
  logic             AddSub_carry;
  logic             AddSub_neg;
  logic             AddSub_err;

  modport master (
    output in_valid, ALU_dat1, ALU_dat2, Instruction_to_ALU, out_ready,
    input  in_ready, out_valid, AddSub_out, AddSub_overflow, AddSub_zero,
           AddSub_carry, AddSub_neg, AddSub_err
  );

  modport slave (
    input  in_valid, ALU_dat1, ALU_dat2, Instruction_to_ALU, out_ready,
    output in_ready, out_valid, AddSub_out, AddSub_overflow, AddSub_zero,
           AddSub_carry, AddSub_neg, AddSub_err
  );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined ADD / SUB / SLT / SLTU unit. The carry chain is cut into
// CHUNK-bit slices, one slice per stage, so latency is WIDTH/CHUNK cycles.
// Ports:
//   soc_clk - clock, rising edge
//   reset   - asynchronous active-low reset
//   bus     - addsub_pipe_if slave: valid/ready input (operands, opcode),
//             valid/ready output (result, overflow/zero/carry/neg/err flags)
// All stages advance together when the output is free or being consumed.
module addsub_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CHUNK   = 8,
  parameter logic [4:0]  OP_ADD  = 5'd6,
  parameter logic [4:0]  OP_SUB  = 5'd7,
  parameter logic [4:0]  OP_SLT  = 5'd8,
  parameter logic [4:0]  OP_SLTU = 5'd9
) (
  input  logic         soc_clk,
  input  logic         reset,
  addsub_pipe_if.slave bus
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;

  typedef enum logic [1:0] {KAdd, KSub, KSlt, KSltu} kind_e;

  // Per-stage state; stage LAST doubles as the output register.
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  kind_e            kind_q  [STAGES];
  kind_e            kind_d  [STAGES];
  logic             err_q   [STAGES];
  logic             err_d   [STAGES];

  logic             en;
  kind_e            kind_in;
  logic             err_in;
  logic             sub_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [CHUNK:0]   slice;

  assign en          = !valid_q[LAST] || bus.out_ready;
  assign bus.in_ready = en;

  always_comb begin
    kind_in = KAdd;
    err_in  = 1'b0;
    case (bus.Instruction_to_ALU)
      OP_ADD:  kind_in = KAdd;
      OP_SUB:  kind_in = KSub;
      OP_SLT:  kind_in = KSlt;
      OP_SLTU: kind_in = KSltu;
      default: err_in  = 1'b1;
    endcase
    // Illegal opcodes flow through as 0 + 0 + 0 so every raw flag comes out 0.
    sub_in = !err_in && (kind_in != KAdd);
    a_in   = err_in ? '0 : bus.ALU_dat1;
    b_in   = err_in ? '0 : (sub_in ? ~bus.ALU_dat2 : bus.ALU_dat2);

    slice = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, sub_in};
    valid_d[0]              = bus.in_valid;
    a_d[0]                  = a_in;
    b_d[0]                  = b_in;
    kind_d[0]               = kind_in;
    err_d[0]                = err_in;
    sum_d[0]                = '0;
    sum_d[0][CHUNK-1:0]     = slice[CHUNK-1:0];
    carry_d[0]              = slice[CHUNK];

    for (int k = 1; k < STAGES; k++) begin
      // Carry-in comes only from the previous stage's registered slice carry.
      slice = {1'b0, a_q[k-1][k*CHUNK +: CHUNK]} + {1'b0, b_q[k-1][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q[k-1]};
      valid_d[k]                = valid_q[k-1];
      a_d[k]                    = a_q[k-1];
      b_d[k]                    = b_q[k-1];
      kind_d[k]                 = kind_q[k-1];
      err_d[k]                  = err_q[k-1];
      sum_d[k]                  = sum_q[k-1];
      sum_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
      carry_d[k]                = slice[CHUNK];
    end
  end

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        kind_q[k]  <= KAdd;
        err_q[k]   <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
        kind_q[k]  <= kind_d[k];
        err_q[k]   <= err_d[k];
      end
    end
  end

  logic             neg_l;
  logic             ovf_l;
  logic             vld_l;
  logic [WIDTH-1:0] result;

  always_comb begin
    vld_l  = valid_q[LAST];
    neg_l  = sum_q[LAST][WIDTH-1];
    ovf_l  = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) && (neg_l != a_q[LAST][WIDTH-1]);
    result = '0;
    if (!err_q[LAST]) begin
      unique case (kind_q[LAST])
        KAdd, KSub: result = sum_q[LAST];
        KSlt:       result = {{(WIDTH-1){1'b0}}, neg_l ^ ovf_l};
        KSltu:      result = {{(WIDTH-1){1'b0}}, ~carry_q[LAST]};
      endcase
    end
    // Gating with valid keeps every output at 0 while the output stage is empty.
    bus.out_valid       = vld_l;
    bus.AddSub_out      = vld_l ? result : '0;
    bus.AddSub_zero     = vld_l && (result == '0);
    bus.AddSub_neg      = vld_l && !err_q[LAST] && neg_l;
    bus.AddSub_carry    = vld_l && !err_q[LAST] && carry_q[LAST];
    bus.AddSub_overflow = vld_l && !err_q[LAST] && ovf_l;
    bus.AddSub_err      = vld_l && err_q[LAST];
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: 32/8 instance for the main checks and a
// 64/16 instance to show carries crossing stage boundaries.
module tb_addsub_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(32)) bus32 ();
  addsub_pipe_if #(.WIDTH(64)) bus64 ();

  addsub_pipe #(.WIDTH(32), .CHUNK(8)) dut32 (
    .soc_clk (clk),
    .reset   (rst_n),
    .bus     (bus32.slave)
  );

  addsub_pipe #(.WIDTH(64), .CHUNK(16)) dut64 (
    .soc_clk (clk),
    .reset   (rst_n),
    .bus     (bus64.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // {overflow, zero, carry, neg, err}
  function automatic logic [4:0] flags32();
    return {bus32.AddSub_overflow, bus32.AddSub_zero, bus32.AddSub_carry,
            bus32.AddSub_neg, bus32.AddSub_err};
  endfunction

  function automatic logic [4:0] flags64();
    return {bus64.AddSub_overflow, bus64.AddSub_zero, bus64.AddSub_carry,
            bus64.AddSub_neg, bus64.AddSub_err};
  endfunction

  // Reference built from signed/unsigned comparisons and wide arithmetic: {out, flags}.
  function automatic logic [36:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint    sa, sb, r;
    logic [32:0] t;
    logic [31:0] s, o;
    logic      c, v;
    if (op != 5'd6 && op != 5'd7 && op != 5'd8 && op != 5'd9) return {32'h0, 5'b01001};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 5'd6) begin
      t = {1'b0, a} + {1'b0, b};
      s = t[31:0];
      c = t[32];
      r = sa + sb;
    end else begin
      s = a - b;
      c = (a >= b);
      r = sa - sb;
    end
    v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    case (op)
      5'd8:    o = {31'h0, ($signed(a) < $signed(b))};
      5'd9:    o = {31'h0, (a < b)};
      default: o = s;
    endcase
    return {o, v, (o == 32'h0), c, s[31], 1'b0};
  endfunction

  task automatic run_one(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_out,
                         input logic [4:0] exp_fl);
    @(negedge clk);
    bus32.in_valid           = 1'b1;
    bus32.Instruction_to_ALU = op;
    bus32.ALU_dat1           = a;
    bus32.ALU_dat2           = b;
    bus32.out_ready          = 1'b1;
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_eq({tag, "_early"}, bus32.out_valid, 0);
    @(posedge clk);
    #1;
    check_eq({tag, "_vld"}, bus32.out_valid, 1);
    check_eq({tag, "_out"}, bus32.AddSub_out, exp_out);
    check_eq({tag, "_flags"}, flags32(), exp_fl);
  endtask

  logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [4:0]  s_op [8];
  logic [31:0] s_a  [8];
  logic [31:0] s_b  [8];
  logic [4:0]  legal [4] = '{5'd6, 5'd7, 5'd8, 5'd9};

  initial begin
    int   sent, got, cyc, rdy_bad, extra, stale;
    logic acc, pop;
    logic [36:0] m;

    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.Instruction_to_ALU = 5'd6;
    bus32.ALU_dat1 = '0;   bus32.ALU_dat2  = '0;
    bus64.in_valid = 1'b0; bus64.out_ready = 1'b1; bus64.Instruction_to_ALU = 5'd6;
    bus64.ALU_dat1 = '0;   bus64.ALU_dat2  = '0;

    #1;
    check_eq("rst_vld", bus32.out_valid, 0);
    check_eq("rst_out", bus32.AddSub_out, 0);
    check_eq("rst_flags", flags32(), 0);
    check_eq("rst_inrdy", bus32.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_one("add_ovf",  5'd6, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b10010);
    run_one("add_wrap", 5'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b01100);
    run_one("sub_m1",   5'd7, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0006, 5'b00000);
    run_one("slt_m1",   5'd8, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0000, 5'b01000);
    run_one("sltu_m1",  5'd9, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0001, 5'b00000);
    run_one("sub_eq",   5'd7, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 5'b01100);
    run_one("sub_brw",  5'd7, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 5'b00010);
    run_one("sub_ovf",  5'd7, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b10100);
    run_one("slt_neg",  5'd8, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0001, 5'b00110);
    run_one("add_pre",  5'd6, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 5'b00000);
    run_one("illegal",  5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5'b01001);
    run_one("sub_post", 5'd7, 32'h0000_0007, 32'h0000_0002, 32'h0000_0005, 5'b00100);

    // Reset mid-stream: three back-to-back ADDs, then a one-cycle reset pulse.
    @(negedge clk);
    bus32.in_valid = 1'b1; bus32.Instruction_to_ALU = 5'd6; bus32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus32.ALU_dat1 = 32'(i + 10);
      bus32.ALU_dat2 = 32'h1;
      @(posedge clk);
      #1;
    end
    bus32.in_valid = 1'b0;
    @(posedge clk);
    #1 check_eq("mid_prevld", bus32.out_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", bus32.out_valid, 0);
    check_eq("mid_rst_out", bus32.AddSub_out, 0);
    check_eq("mid_rst_flags", flags32(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (bus32.out_valid) stale++;
    end
    check_eq("mid_stale", stale, 0);

    // Streaming under backpressure.
    for (int i = 0; i < 8; i++) begin
      s_op[i] = legal[$urandom_range(0, 3)];
      s_a[i]  = $urandom;
      s_b[i]  = $urandom;
    end
    s_a[3] = 32'h8000_0000; s_b[3] = 32'h7FFF_FFFF;
    sent = 0; got = 0; cyc = 0; rdy_bad = 0;
    while (got < 8 && cyc < 300) begin
      @(negedge clk);
      bus32.in_valid = (sent < 8);
      if (sent < 8) begin
        bus32.Instruction_to_ALU = s_op[sent];
        bus32.ALU_dat1           = s_a[sent];
        bus32.ALU_dat2           = s_b[sent];
      end
      bus32.out_ready = pat[cyc % 4];
      #1;
      if (bus32.in_ready !== !(bus32.out_valid && !bus32.out_ready)) rdy_bad++;
      acc = bus32.in_valid && bus32.in_ready;
      pop = bus32.out_valid && bus32.out_ready;
      if (pop && got < 8) begin
        m = model(s_op[got], s_a[got], s_b[got]);
        check_eq($sformatf("strm%0d_out", got), bus32.AddSub_out, m[36:5]);
        check_eq($sformatf("strm%0d_flags", got), flags32(), m[4:0]);
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
      cyc++;
    end
    check_eq("strm_count", got, 8);
    check_eq("strm_inrdy", rdy_bad, 0);
    @(negedge clk);
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (bus32.out_valid) extra++;
    end
    check_eq("strm_extra", extra, 0);

    // 64-bit / 16-bit chunks: carry ripples across the stage-1 boundary.
    @(negedge clk);
    bus64.in_valid = 1'b1; bus64.Instruction_to_ALU = 5'd6;
    bus64.ALU_dat1 = 64'h0000_0000_FFFF_FFFF; bus64.ALU_dat2 = 64'h1;
    @(posedge clk);
    #1 bus64.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_eq("w64_early", bus64.out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("w64_vld", bus64.out_valid, 1);
    check_eq("w64_out", bus64.AddSub_out, 64'h0000_0001_0000_0000);
    check_eq("w64_flags", flags64(), 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined successor to the ALU add/subtract unit.
- Computes ADD, SUB, signed set-less-than (SLT) and unsigned set-less-than (SLTU) on WIDTH-bit operands.
- The carry chain is split into CHUNK-bit slices, one slice per pipeline stage.
- Sits in the ALU datapath behind a valid/ready handshake, so the pipeline stalls cleanly under output backpressure. Reports overflow, zero, carry and negative flags with each result.

Parameters:
- WIDTH, 32, operand and result width. Must be a multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage. Latency STAGES = WIDTH/CHUNK.
- OP_ADD, 6, opcode for add.
- OP_SUB, 7, opcode for subtract.
- OP_SLT, 8, opcode for signed set-less-than.
- OP_SLTU, 9, opcode for unsigned set-less-than.

Ports:
- soc_clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept an input this cycle.
- ALU_dat1  in  WIDTH  operand A.
- ALU_dat2  in  WIDTH  operand B.
- Instruction_to_ALU  in  5  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- AddSub_out  out  WIDTH  result.
- AddSub_overflow  out  1  signed overflow of the add/sub.
- AddSub_zero  out  1  AddSub_out == 0.
- AddSub_carry  out  1  carry out of the MSB.
- AddSub_neg  out  1  MSB of the raw add/sub sum.
- AddSub_err  out  1  opcode was not one of the four legal codes.

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits, partial sums, carries and output registers go to 0. All outputs read 0.
- Deassertion of reset is synchronised by the integrator. Transactions in flight when reset asserts are discarded; no partial result is ever presented.
- Global advance: en = !out_valid | out_ready. in_ready = en.
  - An input is accepted when in_valid & in_ready.
  - Every stage shifts by one when en=1 and holds when en=0.
  - Bubbles are not collapsed.
- Stage 0 (acceptance cycle):
  - B' = ~B for SUB/SLT/SLTU, B for ADD.
  - cin = 1 for SUB/SLT/SLTU, 0 for ADD.
  - Register A, B', opcode, and the sum of slice 0 with its carry.
  - Illegal opcode: register A=0, B'=0, cin=0 and set err.
- Stage k (1..STAGES-1): add slice k of A and B' plus the registered carry from stage k-1. Carry-in comes only from the registered previous slice.
- Output (after the last stage):
  - out_valid rises STAGES cycles after acceptance when no stall occurs. For the default parameters this is 4 cycles: accepted at edge n, visible after edge n+3.
  - ADD/SUB: AddSub_out = sum.
  - SLT: AddSub_out = {0…, N^V}.
  - SLTU: AddSub_out = {0…, ~carry}.
  - err: AddSub_out = 0.
- Flags, taken from the raw sum for all legal ops:
  - AddSub_neg = sum[WIDTH-1].
  - AddSub_carry = carry out of the MSB. For SUB, 1 means no borrow.
  - AddSub_overflow = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]).
  - AddSub_zero reflects AddSub_out, not the raw sum.
  - err transactions: all flags 0 except AddSub_zero=1 and AddSub_err=1.
- Flag timing: flags and AddSub_err are valid only while out_valid=1, and hold stable during a stall.
- Throughput: one result per cycle when out_ready is held high.
- Stall and hold:
  - While out_valid & !out_ready, the output is held and nothing is lost or duplicated.
  - An input offered while in_ready=0 is not taken and must be held by the source.
- Wrap-around: arithmetic is modulo 2^WIDTH and is never saturated.

Test Plan:
- Reset mid-stream: issue 3 back-to-back ADDs, then pull reset low for 1 cycle → out_valid=0 and all outputs 0 immediately; no stale result appears after reset releases.
- ADD, WIDTH=32/CHUNK=8: A=0x7FFFFFFF, B=0x00000001 → 4 cycles later AddSub_out=0x80000000, overflow=1, neg=1, carry=0, zero=0. A=0xFFFFFFFF, B=1 → out=0, zero=1, carry=1, overflow=0.
- SUB/SLT/SLTU with A=5, B=0xFFFFFFFF (−1): SUB → 0x00000006, carry=0; SLT → 0; SLTU → 1. SUB with A=B=0x12345678 → out=0, zero=1, carry=1.
- Streaming with backpressure: 8 consecutive random ops with out_ready toggling 1,0,0,1… → results emerge in order, match the model, none dropped or duplicated, in_ready=0 exactly while stalled.
- Illegal opcode 3 with A=B=0xFFFFFFFF → AddSub_out=0, AddSub_err=1, zero=1, other flags 0; neighbouring legal ops are unaffected.
- Reconfigure WIDTH=64/CHUNK=16: ADD A=0x00000000FFFFFFFF, B=1 → 0x0000000100000000 after 4 cycles, proving the carry crosses stage boundaries.
